bf_loop_stack: RTL and testbench
================================

// Module: bf_loop_stack
// PURPOSE
//   Loop-control stage for the Brainfuck core. Sits directly upstream of the PC counter,
//   driving that counter's D and LOAD inputs.
//   Executes '[' and ']' semantics with a LIFO of loop-entry addresses.
//   Runs a nesting-depth scanner that marks instructions as skipped while a zero-cell loop
//   is bypassed.
// PARAMETERS
//   ADDR_WIDTH  8   width of program addresses; equals the PC counter WIDTH
//   DEPTH_LOG2  4   log2 of stack entries; stack depth = 2**DEPTH_LOG2
//   NEST_WIDTH  8   width of the skip-mode nesting counter
// PORTS
//   CLK        in   1             rising-edge clock
//   RESET_N    in   1             asynchronous, active-low reset
//   EN         in   1             instruction valid strobe, one cycle per instruction
//   OP_OPEN    in   1             instruction is '['; qualified by EN
//   OP_CLOSE   in   1             instruction is ']'; qualified by EN
//   CELL_ZERO  in   1             current data cell == 0; sampled with EN
//   PC         in   ADDR_WIDTH    address of the instruction presented with EN
//   PC_D       out  ADDR_WIDTH    jump target to the PC counter D input
//   PC_LOAD    out  1             one-cycle load pulse to the PC counter (LOAD and EN)
//   SKIP       out  1             core treats the current instruction as a no-op; PC still advances
//   LEVEL      out  DEPTH_LOG2+1  number of valid stack entries, 0..2**DEPTH_LOG2
//   EMPTY      out  1             LEVEL == 0
//   FULL       out  1             LEVEL == 2**DEPTH_LOG2
//   ERROR      out  1             sticky fault flag (overflow, underflow, nest saturate, OPEN&CLOSE)
// BEHAVIOUR
//   Reset (async): state=RUN, LEVEL=0, nest=0, PC_D=0, PC_LOAD=0, SKIP=0, ERROR=0,
//     EMPTY=1, FULL=0. Stack RAM contents are not reset.
//   States: RUN, SKIP, HALT. SKIP output is high only in state SKIP.
//   All actions below require EN=1. With EN=0 nothing changes.
//   EN=1 with neither OP_OPEN nor OP_CLOSE is a no-op in every state.
//   RUN transitions:
//     OPEN & !CELL_ZERO: push PC; LEVEL+1. If FULL: no push, set ERROR.
//     OPEN & CELL_ZERO: no push; nest=1; go to SKIP.
//     CLOSE & !CELL_ZERO: next cycle PC_LOAD=1 and PC_D=TOP+1 (mod 2**ADDR_WIDTH).
//       The stack is unchanged. If EMPTY: no load, set ERROR.
//     CLOSE & CELL_ZERO: pop; LEVEL-1. If EMPTY: set ERROR.
//     OPEN & CLOSE together: ignored; set ERROR.
//   SKIP transitions (stack frozen):
//     OPEN: nest+1. At nest all-ones: hold nest and set ERROR.
//     CLOSE with nest==1: nest=0; go to RUN. SKIP is low from the next cycle.
//     CLOSE otherwise: nest-1.
//   PC_LOAD timing:
//     Registered; high exactly one cycle, the cycle after the sampling edge. Low otherwise.
//     PC_D holds its last target between loads.
//     EN asserted while PC_LOAD=1 is ignored entirely.
//   TOP is the entry at LEVEL-1.
//   A push and a read of the same entry in consecutive cycles returns the new value.
//   ERROR is only cleared by RESET_N.
//   Reset asserted mid-operation aborts SKIP or a pending load immediately, with no PC_LOAD pulse.
// CONFIGURATION
//   BF_LOOP_HALT_ON_ERROR_EN defined:
//     Any ERROR-setting event moves the FSM to HALT.
//     HALT ignores EN forever; SKIP=0, PC_LOAD=0.
//     Only reset leaves HALT.
//   BF_LOOP_HALT_ON_ERROR_EN undefined:
//     HALT is unreachable. The faulting op is dropped, ERROR sets, and the FSM stays in its
//     current state.
// TESTING
//   Reset, then OPEN, !ZERO at PC=0x05 -> LEVEL=1.
//     Then CLOSE, !ZERO -> next cycle PC_LOAD=1, PC_D=0x06. LEVEL stays 1.
//   Nested: OPEN at 0x02 and 0x07 (!ZERO), then CLOSE with ZERO twice
//     -> LEVEL 2,1,0; EMPTY=1; ERROR=0.
//   Skip: OPEN, ZERO; then OPEN, OPEN, CLOSE, CLOSE, CLOSE
//     -> SKIP high from the first OPEN until the cycle after the 3rd CLOSE; LEVEL=0 throughout.
//   Overflow: 17 pushes with DEPTH_LOG2=4 -> FULL=1, LEVEL=16, ERROR=1.
//     Macro on: further EN ignored. Macro off: a CLOSE, ZERO still pops to 15.
//   Underflow: CLOSE, !ZERO on empty -> no PC_LOAD pulse, ERROR=1.
//   Pulse RESET_N low while SKIP=1 and a PC_LOAD is pending
//     -> all outputs return to reset values asynchronously; no load issued.

Source files
------------

// File: rtl/bf_loop_stack.sv
// rtl/bf_loop_stack.sv - loop-control stage: '[' / ']' LIFO, skip scanner, PC jump generation
//
// Purpose:
//   Drives the PC counter's D/LOAD inputs for Brainfuck loop instructions. Loop-entry
//   addresses live in a LIFO. A nesting-depth scanner flags instructions as skipped
//   while a zero-cell loop body is bypassed.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_n_i      asynchronous active-low reset
//   en_i         instruction valid strobe, one cycle per instruction
//   op_open_i    instruction is '[' (qualified by en_i)
//   op_close_i   instruction is ']' (qualified by en_i)
//   cell_zero_i  current data cell is zero (sampled with en_i)
//   pc_i         address of the instruction presented with en_i
//   pc_d_o       jump target for the PC counter
//   pc_load_o    one-cycle load pulse for the PC counter
//   skip_o       current instruction is a no-op (skip mode)
//   level_o      number of valid stack entries
//   empty_o      level_o == 0
//   full_o       level_o == 2**DEPTH_LOG2
//   error_o      sticky fault flag
//
// Configuration macro:
//   BF_LOOP_HALT_ON_ERROR_EN - when defined, any fault parks the FSM in HALT until reset.

module bf_loop_stack #(
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH_LOG2 = 4,
  parameter int NEST_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  en_i,
  input  logic                  op_open_i,
  input  logic                  op_close_i,
  input  logic                  cell_zero_i,
  input  logic [ADDR_WIDTH-1:0] pc_i,
  output logic [ADDR_WIDTH-1:0] pc_d_o,
  output logic                  pc_load_o,
  output logic                  skip_o,
  output logic [DEPTH_LOG2:0]   level_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic                  error_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int LW    = DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_SKIP = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [LW-1:0]           level_q, level_d;
  logic [NEST_WIDTH-1:0]   nest_q, nest_d;
  logic [ADDR_WIDTH-1:0]   pc_d_q, pc_d_d;
  logic                    pc_load_q, pc_load_d;
  logic                    error_q, error_d;
  logic [ADDR_WIDTH-1:0]   stack_q [DEPTH];

  logic                    accept;
  logic                    push;
  logic                    fault;
  logic                    empty;
  logic                    full;
  logic [DEPTH_LOG2-1:0]   top_idx;
  logic [ADDR_WIDTH-1:0]   top;

  assign empty   = (level_q == '0);
  assign full    = (level_q == LW'(DEPTH));
  // When full the low bits wrap to 0, so subtracting one still lands on the last entry.
  assign top_idx = level_q[DEPTH_LOG2-1:0] - DEPTH_LOG2'(1);
  // Combinational read of registered storage: a push is visible on the very next cycle.
  assign top     = stack_q[top_idx];

  // An instruction arriving while a load pulse is out is dropped: the PC is being redirected.
  assign accept  = en_i && !pc_load_q;

  always_comb begin
    state_d   = state_q;
    level_d   = level_q;
    nest_d    = nest_q;
    pc_d_d    = pc_d_q;
    pc_load_d = 1'b0;
    error_d   = error_q;
    push      = 1'b0;
    fault     = 1'b0;

    if (accept) begin
      case (state_q)
        ST_RUN: begin
          if (op_open_i && op_close_i) begin
            fault = 1'b1;
          end else if (op_open_i) begin
            if (cell_zero_i) begin
              nest_d  = NEST_WIDTH'(1);
              state_d = ST_SKIP;
            end else if (full) begin
              fault = 1'b1;
            end else begin
              push    = 1'b1;
              level_d = level_q + LW'(1);
            end
          end else if (op_close_i) begin
            if (empty) begin
              fault = 1'b1;
            end else if (!cell_zero_i) begin
              pc_load_d = 1'b1;
              pc_d_d    = top + ADDR_WIDTH'(1);
            end else begin
              level_d = level_q - LW'(1);
            end
          end
        end
        ST_SKIP: begin
          if (op_open_i && op_close_i) begin
            fault = 1'b1;
          end else if (op_open_i) begin
            if (&nest_q) fault = 1'b1;
            else         nest_d = nest_q + NEST_WIDTH'(1);
          end else if (op_close_i) begin
            if (nest_q == NEST_WIDTH'(1)) begin
              nest_d  = '0;
              state_d = ST_RUN;
            end else begin
              nest_d = nest_q - NEST_WIDTH'(1);
            end
          end
        end
        default: ;
      endcase
    end

    if (fault) begin
      error_d = 1'b1;
`ifdef BF_LOOP_HALT_ON_ERROR_EN
      state_d = ST_HALT;
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_RUN;
      level_q   <= '0;
      nest_q    <= '0;
      pc_d_q    <= '0;
      pc_load_q <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      nest_q    <= nest_d;
      pc_d_q    <= pc_d_d;
      pc_load_q <= pc_load_d;
      error_q   <= error_d;
    end
  end

  // Stack storage is deliberately not reset; LEVEL alone defines which entries are valid.
  always_ff @(posedge clk_i) begin
    if (push) stack_q[level_q[DEPTH_LOG2-1:0]] <= pc_i;
  end

  assign pc_d_o    = pc_d_q;
  assign pc_load_o = pc_load_q;
  assign skip_o    = (state_q == ST_SKIP);
  assign level_o   = level_q;
  assign empty_o   = empty;
  assign full_o    = full;
  assign error_o   = error_q;

endmodule

// File: tb/tb_bf_loop_stack.sv
// tb/tb_bf_loop_stack.sv - scoreboard bench for bf_loop_stack with a queue-based loop model

module tb_bf_loop_stack;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       op_open;
  logic       op_close;
  logic       cell_zero;
  logic [7:0] pc;
  logic [7:0] pc_d;
  logic       pc_load;
  logic       skip;
  logic [4:0] level;
  logic       empty;
  logic       full;
  logic       error;

  bf_loop_stack #(.ADDR_WIDTH(8), .DEPTH_LOG2(4), .NEST_WIDTH(8)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .en_i        (en),
    .op_open_i   (op_open),
    .op_close_i  (op_close),
    .cell_zero_i (cell_zero),
    .pc_i        (pc),
    .pc_d_o      (pc_d),
    .pc_load_o   (pc_load),
    .skip_o      (skip),
    .level_o     (level),
    .empty_o     (empty),
    .full_o      (full),
    .error_o     (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int pc_d;
    int pc_load;
    int skip;
    int level;
    int empty;
    int full;
    int error;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: loop addresses in a queue, mode 0=run 1=skipping 2=halted.
  int m_stk[$];
  int m_mode;
  int m_nest;
  int m_err;
  int m_load;
  int m_pcd;

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, expv, $time);
    end
  endtask

  function automatic void model_reset();
    m_stk.delete();
    m_mode = 0;
    m_nest = 0;
    m_err  = 0;
    m_load = 0;
    m_pcd  = 0;
  endfunction

  function automatic void model_step(input int e, input int o, input int c, input int z, input int p);
    int ld;
    int flt;
    ld  = 0;
    flt = 0;
    if (e != 0 && m_load == 0 && m_mode != 2) begin
      if (o != 0 && c != 0) begin
        flt = 1;
      end else if (m_mode == 0) begin
        if (o != 0) begin
          if (z != 0) begin
            m_nest = 1;
            m_mode = 1;
          end else if (m_stk.size() == 16) flt = 1;
          else m_stk.push_back(p);
        end else if (c != 0) begin
          if (m_stk.size() == 0) flt = 1;
          else if (z == 0) begin
            ld    = 1;
            m_pcd = (m_stk[m_stk.size()-1] + 1) % 256;
          end else void'(m_stk.pop_back());
        end
      end else begin
        if (o != 0) begin
          if (m_nest == 255) flt = 1;
          else m_nest = m_nest + 1;
        end else if (c != 0) begin
          m_nest = m_nest - 1;
          if (m_nest == 0) m_mode = 0;
        end
      end
    end
    m_load = ld;
    if (flt != 0) begin
      m_err = 1;
`ifdef BF_LOOP_HALT_ON_ERROR_EN
      m_mode = 2;
`endif
    end
  endfunction

  function automatic exp_t model_outputs();
    exp_t x;
    x.pc_d    = m_pcd;
    x.pc_load = m_load;
    x.skip    = (m_mode == 1) ? 1 : 0;
    x.level   = m_stk.size();
    x.empty   = (m_stk.size() == 0) ? 1 : 0;
    x.full    = (m_stk.size() == 16) ? 1 : 0;
    x.error   = m_err;
    return x;
  endfunction

  // One instruction slot: drive at the falling edge, record the post-edge expectation.
  task automatic step(input int e, input int o, input int c, input int z, input int p);
    @(negedge clk);
    en        = (e != 0);
    op_open   = (o != 0);
    op_close  = (c != 0);
    cell_zero = (z != 0);
    pc        = 8'(p);
    model_step(e, o, c, z, p);
    exp_q.push_back(model_outputs());
  endtask

  // Mid-cycle asynchronous reset; outputs must settle before any clock edge arrives.
  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    en    = 1'b0;
    #1;
    chk("rst_pc_d",    int'(pc_d),    0);
    chk("rst_pc_load", int'(pc_load), 0);
    chk("rst_skip",    int'(skip),    0);
    chk("rst_level",   int'(level),   0);
    chk("rst_empty",   int'(empty),   1);
    chk("rst_full",    int'(full),    0);
    chk("rst_error",   int'(error),   0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        chk("pc_d",    int'(pc_d),    x.pc_d);
        chk("pc_load", int'(pc_load), x.pc_load);
        chk("skip",    int'(skip),    x.skip);
        chk("level",   int'(level),   x.level);
        chk("empty",   int'(empty),   x.empty);
        chk("full",    int'(full),    x.full);
        chk("error",   int'(error),   x.error);
      end
    end
  end

  initial begin : driver
    int r;
    int o;
    int c;
    rst_n     = 1'b0;
    en        = 1'b0;
    op_open   = 1'b0;
    op_close  = 1'b0;
    cell_zero = 1'b0;
    pc        = 8'h00;
    model_reset();
    #12;
    rst_n = 1'b1;
    do_reset();

    // Basic loop: push at 0x05, back-jump to 0x06, stack kept.
    step(1, 1, 0, 0, 8'h05);
    step(1, 0, 1, 0, 8'h09);
    step(1, 0, 0, 0, 8'h0a);
    step(0, 0, 0, 0, 8'h0b);
    do_reset();

    // Nested loops exit with zero cell.
    step(1, 1, 0, 0, 8'h02);
    step(1, 1, 0, 0, 8'h07);
    step(1, 0, 1, 1, 8'h08);
    step(1, 0, 1, 1, 8'h09);
    step(0, 0, 0, 0, 8'h0a);
    do_reset();

    // Skip scanner across a nested zero-cell loop.
    step(1, 1, 0, 1, 8'h01);
    step(1, 1, 0, 0, 8'h02);
    step(1, 1, 0, 0, 8'h03);
    step(1, 0, 1, 0, 8'h04);
    step(1, 0, 1, 0, 8'h05);
    step(1, 0, 1, 0, 8'h06);
    step(0, 0, 0, 0, 8'h07);
    do_reset();

    // Overflow then a pop attempt; jump target wraps at 0xFF.
    for (int i = 0; i < 17; i++) step(1, 1, 0, 0, (i == 15) ? 8'hff : i);
    step(1, 0, 1, 0, 8'h20);
    step(0, 0, 0, 0, 8'h21);
    step(1, 0, 1, 1, 8'h22);
    step(0, 0, 0, 0, 8'h23);
    do_reset();

    // Underflow on an empty stack.
    step(1, 0, 1, 0, 8'h10);
    step(0, 0, 0, 0, 8'h11);
    do_reset();

    // Reset while a load pulse is out, and while skipping.
    step(1, 1, 0, 0, 8'h30);
    step(1, 0, 1, 0, 8'h31);
    do_reset();
    step(1, 1, 0, 1, 8'h40);
    step(1, 1, 0, 0, 8'h41);
    do_reset();

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      r = $urandom_range(0, 99);
      o = 0;
      c = 0;
      if (r < 40)      o = 1;
      else if (r < 80) c = 1;
      else if (r < 82) begin o = 1; c = 1; end
      step(($urandom_range(0, 9) < 8) ? 1 : 0, o, c,
           ($urandom_range(0, 9) < 3) ? 1 : 0, $urandom_range(0, 255));
    end

    step(0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
